// File: rtl/mmio_uart_pkg.sv
// Shared register map, STATUS bit layout and transmitter FSM states for the MMIO UART TX block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmio_uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-bus slave port of the MMIO UART TX: select, store strobe, address, data, byte lanes, read data.
// Latency: read data is combinational; stores take effect on the sampling clk edge.
// Backpressure: none, the slave accepts every access.
interface mmio_uart_tx_if;
    logic        sel;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ByteMask;
    logic [31:0] rd;

    modport master (output sel, we, a, wd, ByteMask, input rd);
    modport slave  (input sel, we, a, wd, ByteMask, output rd);
endinterface

// File: rtl/uart_txfifo.sv
// Byte FIFO feeding the UART serialiser; registered count, full and empty flags.
// Latency: a pushed byte is visible at the head one edge later.
// Backpressure: push is refused when full unless a pop happens on the same edge; pop on empty is ignored.
module uart_txfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign data    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS/DIVISOR registers, byte FIFO, 8N1 serialiser (even parity bit with UART_TX_PARITY_EN).
// Latency: a byte pushed into an idle, empty block drives the start bit from the next clk edge; frames run back-to-back.
// Backpressure: none on the bus; a push into a full FIFO with no same-cycle pop is dropped and sets sticky STATUS.ovf.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          txd
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     state;
    tx_state_e     state_nxt;
    logic [15:0]   divisor;
    logic [15:0]   div_lat;
    logic [15:0]   div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          ovf;
    logic          pop;
    logic          bit_done;
    logic          bus_wr;
    logic [1:0]    reg_sel;
    logic          push_req;
    logic          ovf_set;
    logic          ovf_clr;
    logic          div_wr;
    logic [7:0]    head;
    logic [CW-1:0] fifo_count;
    logic [7:0]    count_ext;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   rd_dat;
    logic          unused_bits;
`ifdef UART_TX_PARITY_EN
    logic          par_bit;
`endif

    assign bus_wr   = bus.sel && bus.we;
    assign reg_sel  = bus.a[3:2];
    assign push_req = bus_wr && (reg_sel == REG_TXDATA) && bus.ByteMask[0];
    assign ovf_set  = push_req && fifo_full && !pop;
    assign ovf_clr  = bus_wr && (reg_sel == REG_STATUS) && bus.ByteMask[0] && bus.wd[3];
    assign div_wr   = bus_wr && (reg_sel == REG_DIVISOR) && (bus.ByteMask[1:0] == 2'b11)
                      && (bus.wd[15:0] != 16'd0);
    assign bit_done = (div_cnt == div_lat - 16'd1);

    uart_txfifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_req),
        .push_dat (bus.wd[7:0]),
        .pop      (pop),
        .data     (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = S_START;
                    pop       = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_done && (bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                if (bit_done) state_nxt = S_STOP;
            end
            S_STOP: begin
                // A waiting byte starts its frame straight after the stop bit, with no idle gap.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        state_nxt = S_START;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The divisor is latched per frame so that a mid-frame DIVISOR write only affects later frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_lat <= 16'(CLKS_PER_BIT);
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (pop) begin
            div_lat <= divisor;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= head;
        end else if (state != S_IDLE) begin
            if (bit_done) begin
                div_cnt <= '0;
                if (state == S_DATA) begin
                    shreg <= shreg >> 1;
                    if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   par_bit <= 1'b0;
        else if (pop) par_bit <= even_parity(head);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor <= 16'(CLKS_PER_BIT);
            ovf     <= 1'b0;
        end else begin
            if (div_wr) divisor <= bus.wd[15:0];
            // A drop on the same edge as a clear wins, so no overflow is ever lost.
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    always_comb begin
        case (state)
            S_START: txd = 1'b0;
            S_DATA:  txd = shreg[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd = par_bit;
`endif
            default: txd = 1'b1;
        endcase
    end

    assign count_ext = 8'(fifo_count);

    always_comb begin
        rd_dat = '0;
        if (bus.sel) begin
            case (reg_sel)
                REG_STATUS: begin
                    rd_dat[ST_BUSY]             = (state != S_IDLE);
                    rd_dat[ST_FULL]             = fifo_full;
                    rd_dat[ST_EMPTY]            = fifo_empty;
                    rd_dat[ST_OVF]              = ovf;
                    rd_dat[ST_COUNT_LSB +: 4]   = count_ext[3:0];
                end
                REG_DIVISOR: rd_dat[15:0] = divisor;
                default:     rd_dat = '0;
            endcase
        end
    end

    assign bus.rd = rd_dat;

    assign unused_bits = ^{bus.a[31:4], bus.a[1:0], bus.wd[31:16], bus.ByteMask[3:2], count_ext[7:4]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-timeline reference model compared every cycle, plus hand-computed directed checks.
module tb_mmio_uart_tx;

    localparam int DEPTH = 4;
    localparam int DEF_DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic txd;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .CLKS_PER_BIT (DEF_DIV),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: a byte queue plus the position inside the current frame.
    logic [7:0]  mq[$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_div = 16'(DEF_DIV);
    logic        m_act = 1'b0;
    int          m_cyc = 0;
    int          m_fdiv = DEF_DIV;
    logic [7:0]  m_byte = 8'h00;

    task automatic model_step();
        logic last;
        logic pop;
        logic push;
        logic acc;
        if (!reset) begin
            mq.delete();
            m_ovf = 1'b0;
            m_div = 16'(DEF_DIV);
            m_act = 1'b0;
            m_cyc = 0;
            return;
        end
        last = m_act && (m_cyc == NB * m_fdiv - 1);
        pop  = (!m_act || last) && (mq.size() > 0);
        push = bus.sel && bus.we && (bus.a[3:2] == 2'd0) && bus.ByteMask[0];
        acc  = push && ((mq.size() < DEPTH) || pop);
        if (pop) begin
            m_byte = mq.pop_front();
            m_act  = 1'b1;
            m_cyc  = 0;
            m_fdiv = int'(m_div);
        end else if (last) begin
            m_act = 1'b0;
        end else if (m_act) begin
            m_cyc++;
        end
        if (acc) mq.push_back(bus.wd[7:0]);
        if (push && !acc) m_ovf = 1'b1;
        else if (bus.sel && bus.we && bus.a[3:2] == 2'd1 && bus.ByteMask[0] && bus.wd[3]) m_ovf = 1'b0;
        if (bus.sel && bus.we && bus.a[3:2] == 2'd2 && bus.ByteMask[1:0] == 2'b11 && bus.wd[15:0] != 16'd0)
            m_div = bus.wd[15:0];
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    function automatic logic exp_txd();
        int idx;
        if (!m_act) return 1'b1;
        idx = m_cyc / m_fdiv;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
        if (NB == 11 && idx == 9) return ^m_byte;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd();
        logic [31:0] r;
        int n;
        r = '0;
        n = mq.size();
        if (!bus.sel) return r;
        case (bus.a[3:2])
            2'd1: begin
                r[7:4] = 4'(n);
                r[3]   = m_ovf;
                r[2]   = (n == 0);
                r[1]   = (n == DEPTH);
                r[0]   = m_act;
            end
            2'd2:    r[15:0] = m_div;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        check("model_txd", {31'd0, txd}, {31'd0, exp_txd()});
        check("model_rd", bus.rd, exp_rd());
    end

    task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] m);
        bus.sel = 1'b1;
        bus.we = 1'b1;
        bus.a = {28'd0, off, 2'b00};
        bus.wd = d;
        bus.ByteMask = m;
        @(posedge clk);
        #1;
        bus.sel = 1'b0;
        bus.we = 1'b0;
        bus.a = '0;
        bus.wd = '0;
        bus.ByteMask = '0;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] off, input logic [31:0] exp);
        bus.sel = 1'b1;
        bus.we = 1'b0;
        bus.a = {28'd0, off, 2'b00};
        #1;
        check(nm, bus.rd, exp);
        bus.sel = 1'b0;
        bus.a = '0;
    endtask

    task automatic wait_until(input int unsigned n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  a5_frame;
        int unsigned n;
        bus.sel = 1'b0;
        bus.we = 1'b0;
        bus.a = '0;
        bus.wd = '0;
        bus.ByteMask = '0;
        a5_frame = 10'b1_10100101_0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd_low", {31'd0, txd}, 32'd1);
        rd_chk("rst_status", 2'd1, 32'h04);
        rd_chk("rst_divisor", 2'd2, 32'd16);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Ignored accesses
        wr(2'd0, 32'h5A5A5A5A, 4'b1110);
        wr(2'd3, 32'hFFFFFFFF, 4'hF);
        wr(2'd2, 32'h00000007, 4'b0001);
        @(posedge clk);
        #1;
        rd_chk("mask0_push_ignored", 2'd1, 32'h04);
        rd_chk("div_partial_ignored", 2'd2, 32'd16);
        rd_chk("rsvd_read", 2'd3, 32'h0);
        @(posedge clk);
        #1;
        rd_chk("txdata_read", 2'd0, 32'h0);
        check("idle_txd", {31'd0, txd}, 32'd1);

        // Single 0xA5 frame at divisor 4
        wr(2'd2, 32'h00000004, 4'b0011);
        rd_chk("div4_readback", 2'd2, 32'd4);
        wr(2'd0, {4{8'hA5}}, 4'b0001);
        check("a5_before_start", {31'd0, txd}, 32'd1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            check("a5_frame_bit", {31'd0, txd}, {31'd0, a5_frame[(k-1)/4]});
        end
        @(posedge clk);
        #1;
        check("a5_after", {31'd0, txd}, 32'd1);
        rd_chk("a5_idle_status", 2'd1, 32'h04);

        // Burst of 5, one dropped push, one accepted on a same-edge pop
        wr(2'd0, {4{8'h11}}, 4'b0001);
        n = cyc;
        wr(2'd0, {4{8'h22}}, 4'b0001);
        wr(2'd0, {4{8'h33}}, 4'b0001);
        wr(2'd0, {4{8'h44}}, 4'b0001);
        wr(2'd0, {4{8'h55}}, 4'b0001);
        rd_chk("burst_full", 2'd1, 32'h43);
        wr(2'd0, {4{8'h66}}, 4'b0001);
        rd_chk("drop_ovf", 2'd1, 32'h4B);
        wait_until(n + 40);
        check("b2b_stop", {31'd0, txd}, 32'd1);
        wr(2'd0, {4{8'h77}}, 4'b0001);
        check("b2b_start", {31'd0, txd}, 32'd0);
        rd_chk("push_on_pop", 2'd1, 32'h4B);
        wait_until(n + 240);
        rd_chk("last_stop_busy", 2'd1, 32'h0D);
        wait_until(n + 241);
        rd_chk("all_sent", 2'd1, 32'h0C);
        wr(2'd1, 32'h00000008, 4'b0001);
        rd_chk("ovf_cleared", 2'd1, 32'h04);

        // Divisor change mid-frame
        wr(2'd0, {4{8'h3C}}, 4'b0001);
        n = cyc;
        wr(2'd0, {4{8'hC3}}, 4'b0001);
        wr(2'd2, 32'h00000008, 4'b0011);
        rd_chk("div8_readback", 2'd2, 32'd8);
        wait_until(n + 40);
        check("div_f1_stop", {31'd0, txd}, 32'd1);
        wait_until(n + 48);
        check("div_f2_start_end", {31'd0, txd}, 32'd0);
        wait_until(n + 49);
        check("div_f2_bit0", {31'd0, txd}, 32'd1);
        wr(2'd2, 32'h00000000, 4'b0011);
        rd_chk("div_zero_ignored", 2'd2, 32'd8);
        wait_until(n + 125);
        rd_chk("div_idle", 2'd1, 32'h04);

        // Reset during data bit 3
        wr(2'd0, {4{8'h00}}, 4'b0001);
        n = cyc;
        wait_until(n + 35);
        check("pre_rst_txd", {31'd0, txd}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_txd_now", {31'd0, txd}, 32'd1);
        rd_chk("rst_mid_status", 2'd1, 32'h04);
        rd_chk("rst_mid_div", 2'd2, 32'd16);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        check("no_resume", {31'd0, txd}, 32'd1);
        rd_chk("no_resume_status", 2'd1, 32'h04);

`ifdef UART_TX_PARITY_EN
        wr(2'd2, 32'h00000004, 4'b0011);
        wr(2'd0, {4{8'h07}}, 4'b0001);
        n = cyc;
        wait_until(n + 38);
        check("parity_bit", {31'd0, txd}, 32'd1);
        wait_until(n + 44);
        rd_chk("parity_stop_busy", 2'd1, 32'h05);
        wait_until(n + 45);
        rd_chk("parity_done", 2'd1, 32'h04);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
